dvp_rgb565_capture: RTL
=======================

# dvp_rgb565_capture

Front-end capture stage that sits directly upstream of `sobel_processor`. It samples the camera's 8-bit DVP byte stream (`cam_href`, `cam_vsync`, `cam_data`) in the system clock domain and pairs bytes into RGB565 pixels. It frames them against `IMG_WIDTH`×`IMG_HEIGHT`, then presents `pixel_out`/`href_out`/`vsync_out` in exactly the form `sobel_processor` consumes. It also drops malformed lines, tracks pixel coordinates, counts frames, and flags geometry errors.

## Interface
- `IMG_WIDTH`, 640, pixels per line accepted.
- `IMG_HEIGHT`, 480, lines per frame accepted.
- `clk`  in  1  system clock; camera PCLK is already in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `cam_vsync`  in  1  frame sync, active low; a low pulse separates frames.
- `cam_href`  in  1  line valid; one byte per cycle while high.
- `cam_data`  in  8  camera byte; high byte of each pixel first.
- `capture_enable`  in  1  frame gate; sampled only at frame start.
- `pixel_out`  out  16  assembled RGB565 pixel.
- `href_out`  out  1  per-pixel valid for `sobel_processor`.
- `vsync_out`  out  1  `cam_vsync` delayed to align with the pixel path.
- `x_cnt`  out  10  column of the current `pixel_out`.
- `y_cnt`  out  9  row of the current `pixel_out`.
- `frame_done`  out  1  1-cycle pulse at the end of a captured frame.
- `frame_count`  out  8  captured frames; wraps from 255 to 0.
- `line_error`  out  1  1-cycle pulse on a malformed line.
- `frame_error`  out  1  1-cycle pulse, coincident with `frame_done`, when the line count is not `IMG_HEIGHT`.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are registered once. Edge detection uses this registered copy against its own previous value.
- FSM states:
  - IDLE: reset state; wait for a vsync falling edge.
  - SYNC: vsync is low; on the vsync rising edge go to ACTIVE if `capture_enable`=1, otherwise go to SKIP.
  - ACTIVE: lines are captured.
  - SKIP: all bytes are ignored; a vsync falling edge returns the FSM to SYNC.
- In ACTIVE, a vsync falling edge does the following, then moves to SYNC:
  - pulses `frame_done`;
  - increments `frame_count`;
  - pulses `frame_error` if the captured line count is not `IMG_HEIGHT`.
- Byte pairing, in ACTIVE with href high:
  - A phase bit toggles on every byte.
  - Phase 0 latches the high byte.
  - Phase 1 forms {high, low} and emits one pixel.
  - The phase bit is cleared on every href rising edge.
- `x_cnt` increments after each emitted pixel and clears on the href rising edge.
- `y_cnt` increments at the href falling edge of any line that emitted at least one pixel. It clears at the vsync rising edge.
- Overflow rules:
  - Pixels beyond `IMG_WIDTH` in a line are dropped.
  - Whole lines beyond `IMG_HEIGHT` are dropped.
  - Dropped pixels produce no `href_out`.
- `line_error` pulses at the href falling edge when any of these hold: the pixel count is not `IMG_WIDTH`, the byte count was odd (the trailing half pixel is discarded), or an overflow occurred. It also pulses when href is high while vsync is low; that partial line is discarded.
- Simultaneous events:
  - A vsync falling edge in the same cycle as an href falling edge: `line_error` is evaluated first, then `frame_done`/`frame_error`. Both pulses fire in the same cycle.
  - Toggling `capture_enable` mid-frame has no effect until the next vsync rising edge.
- Reset mid-frame: all state clears and the FSM enters IDLE, so the remainder of the current frame is never captured.
- Reset values: every output is 0, except `vsync_out`, which is 1.

## Timing
- Latency: the low byte is sampled at edge t, and `href_out`/`pixel_out`/`x_cnt`/`y_cnt` are valid in the cycle following edge t+2, i.e. 2 cycles later.
- `vsync_out` is delayed by the same 2 cycles.
- With continuous href, `href_out` is high every other cycle, so a full line emits `IMG_WIDTH` pulses.
- `pixel_out` holds its last value while `href_out` is low.
- `frame_done`, `frame_error` and `line_error` are registered 1-cycle pulses, issued 2 cycles after the sampled edge that triggers them.
- No back-pressure: the downstream stage always accepts.

## Structure
- Shared package `sobel_pkg` holds:
  - the FSM state enum `cap_state_t` (IDLE, SYNC, ACTIVE, SKIP);
  - the localparams `CAP_XW`=10 and `CAP_YW`=9;
  - the RGB565 field-slice constants.
- Natural sub-module `dvp_byte_pairer`: phase bit, high-byte latch, odd-byte detect. The FSM, counters and error logic stay in the top level.

## Test plan
- Nominal frame: one 640×480 frame, 1280 bytes per line, 5-cycle blanking between lines.
  - `href_out` pulses exactly 307200 times.
  - `frame_done`=1 once; `frame_error`=0; `frame_count`=1.
  - Byte pair 0xF8, 0x1F gives `pixel_out`=16'hF81F.
- Odd byte count: one line of 1281 bytes.
  - 640 pixels emitted.
  - `line_error` pulses once, 2 cycles after the href fall.
  - The next line starts at `x_cnt`=0 with phase 0.
- Short frame: 479 lines, then a vsync pulse.
  - `frame_done` and `frame_error` both pulse in the same cycle.
- Long line: a 1300-byte line.
  - Only 640 `href_out` pulses.
  - `line_error`=1.
  - Last emitted `x_cnt`=639.
- `capture_enable`=0 sampled at the vsync rising edge, then driven to 1 mid-frame.
  - No `href_out` for that frame; `frame_count` unchanged.
  - The next frame is captured.
- `rst` asserted at row 200, column 300, then released mid-frame.
  - All outputs are 0 (`vsync_out`=1).
  - No `href_out` until after the next complete vsync pulse.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the camera capture front end and the Sobel pipeline.
//
// Contents:
//   cap_state_t           capture FSM states (IDLE, SYNC, ACTIVE, SKIP)
//   CAP_XW / CAP_YW       widths of the column / row coordinates
//   RGB_*_MSB / RGB_*_LSB bit positions of the R, G and B fields in an RGB565 word
//   rgb565_pack()         joins the high and low camera bytes into one pixel
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        SKIP   = 2'd3
    } cap_state_t;

    localparam int CAP_XW = 10;
    localparam int CAP_YW = 9;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    // The camera sends the red/upper-green byte first, so it becomes the MSBs.
    function automatic logic [15:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/dvp_byte_pairer.sv
// Pairs consecutive DVP bytes into 16-bit RGB565 pixels.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   byte_valid   a camera byte is present this cycle (registered href)
//   line_start   first byte of a line (href rising edge)
//   line_end     first cycle after a line (href falling edge)
//   byte_in      camera byte
//   pixel        assembled pixel, held between emissions
//   pixel_valid  one-cycle strobe when pixel is updated
//   line_end_q   line_end delayed to line up with pixel_valid
//   odd_q        with line_end_q: the line carried an odd number of bytes
module dvp_byte_pairer
    import sobel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic        line_start,
    input  logic        line_end,
    input  logic [7:0]  byte_in,
    output logic [15:0] pixel,
    output logic        pixel_valid,
    output logic        line_end_q,
    output logic        odd_q
);

    logic       phase;
    logic [7:0] high_byte;
    logic       phase_eff;

    // The first byte of every line is a high byte, whatever the previous line left behind.
    assign phase_eff = line_start ? 1'b0 : phase;

    // Phase 0 stores the high byte, phase 1 completes the pixel. After the last byte
    // the phase bit is left untouched, so at the line end it directly tells whether a
    // half pixel was dangling.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= 1'b0;
            high_byte   <= 8'h00;
            pixel       <= 16'h0000;
            pixel_valid <= 1'b0;
            line_end_q  <= 1'b0;
            odd_q       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            line_end_q  <= line_end;
            odd_q       <= line_end & phase;
            if (byte_valid) begin
                phase <= ~phase_eff;
                if (!phase_eff) begin
                    high_byte <= byte_in;
                end else begin
                    pixel       <= rgb565_pack(high_byte, byte_in);
                    pixel_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dvp_rgb565_capture.sv
// DVP camera capture stage feeding sobel_processor: registers the camera bus,
// pairs bytes into RGB565 pixels, frames them to IMG_WIDTH x IMG_HEIGHT, tracks
// coordinates, counts frames and flags malformed lines and frames.
//
// Ports:
//   clk, rst         system clock (camera PCLK domain), synchronous active-high reset
//   cam_vsync        frame sync, active low
//   cam_href         line valid, one byte per cycle while high
//   cam_data         camera byte, high byte of each pixel first
//   capture_enable   frame gate, looked at only when a frame starts
//   pixel_out        assembled pixel, held while href_out is low
//   href_out         per-pixel valid
//   vsync_out        cam_vsync delayed to line up with the pixel path
//   x_cnt / y_cnt    column / row of the current pixel_out
//   frame_done       pulse at the end of a captured frame
//   frame_count      number of captured frames, wrapping
//   line_error       pulse on a malformed line
//   frame_error      pulse with frame_done when the row count is wrong
module dvp_rgb565_capture
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_enable,
    output logic [15:0]       pixel_out,
    output logic              href_out,
    output logic              vsync_out,
    output logic [CAP_XW-1:0] x_cnt,
    output logic [CAP_YW-1:0] y_cnt,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_error,
    output logic              frame_error
);

    localparam logic [CAP_XW-1:0] WIDTH_L  = CAP_XW'(IMG_WIDTH);
    localparam logic [CAP_YW-1:0] HEIGHT_L = CAP_YW'(IMG_HEIGHT);

    logic       vsync_r, href_r;
    logic [7:0] data_r;
    logic       vsync_q, href_q;
    logic       vs_fall_q, vs_rise_q, href_rise_q;
    logic       href_rise, href_fall, vs_fall, vs_rise;

    logic [15:0] pair_pixel;
    logic        pair_valid, href_fall_q, pair_odd;

    cap_state_t        state, next_state;
    logic [CAP_XW-1:0] col_cnt;
    logic [CAP_YW-1:0] row_cnt;
    logic              line_dirty, line_ovf, extra_lines;

    logic              tracking, dirty_now, ovf_now, capture, emit, overflow;
    logic              line_bad, row_inc, extra_now, frame_end, frame_bad;
    logic [CAP_YW-1:0] row_next;

    // Stage 1: plain register of the camera bus. Stage 2: the previous stage-1 value,
    // which doubles as the reference for edge detection, plus the registered edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_r     <= 1'b1;
            href_r      <= 1'b0;
            data_r      <= 8'h00;
            vsync_q     <= 1'b1;
            href_q      <= 1'b0;
            vs_fall_q   <= 1'b0;
            vs_rise_q   <= 1'b0;
            href_rise_q <= 1'b0;
        end else begin
            vsync_r     <= cam_vsync;
            href_r      <= cam_href;
            data_r      <= cam_data;
            vsync_q     <= vsync_r;
            href_q      <= href_r;
            vs_fall_q   <= vs_fall;
            vs_rise_q   <= vs_rise;
            href_rise_q <= href_rise;
        end
    end

    assign href_rise = href_r & ~href_q;
    assign href_fall = ~href_r & href_q;
    assign vs_fall   = vsync_q & ~vsync_r;
    assign vs_rise   = ~vsync_q & vsync_r;

    dvp_byte_pairer u_pairer (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (href_r),
        .line_start  (href_rise),
        .line_end    (href_fall),
        .byte_in     (data_r),
        .pixel       (pair_pixel),
        .pixel_valid (pair_valid),
        .line_end_q  (href_fall_q),
        .odd_q       (pair_odd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the per-cycle line/frame decisions. Everything here looks at
    // stage-2 signals, so edges, levels and pair_valid all describe the same byte.
    // A line is "dirty" once href was seen high with vsync low; its pixels are
    // discarded and it is reported when it ends. A line end and a frame end in the
    // same cycle are both honoured: the row increment from that line is already
    // folded into row_next before the frame row count is judged.
    always_comb begin
        next_state = state;
        tracking   = (state == ACTIVE) || (state == SYNC);
        dirty_now  = (href_rise_q ? 1'b0 : line_dirty) | (tracking & href_q & ~vsync_q);
        ovf_now    = href_rise_q ? 1'b0 : line_ovf;
        capture    = (state == ACTIVE) & pair_valid & ~dirty_now;
        emit       = capture & (col_cnt < WIDTH_L) & (row_cnt < HEIGHT_L);
        overflow   = capture & ~emit;
        line_bad   = href_fall_q & tracking &
                     (dirty_now | ovf_now | overflow | pair_odd | (col_cnt != WIDTH_L));
        row_inc    = href_fall_q & (state == ACTIVE) & (col_cnt != '0);
        row_next   = row_cnt + CAP_YW'(row_inc);
        extra_now  = extra_lines | (overflow & (row_cnt >= HEIGHT_L));
        frame_end  = (state == ACTIVE) & vs_fall_q;
        frame_bad  = frame_end & ((row_next != HEIGHT_L) | extra_now);

        case (state)
            IDLE:    if (vs_fall_q) next_state = SYNC;
            SYNC:    if (vs_rise_q) next_state = capture_enable ? ACTIVE : SKIP;
            ACTIVE:  if (vs_fall_q) next_state = SYNC;
            SKIP:    if (vs_fall_q) next_state = SYNC;
            default: next_state = IDLE;
        endcase
    end

    // Stage 3: counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out   <= 16'h0000;
            href_out    <= 1'b0;
            vsync_out   <= 1'b1;
            x_cnt       <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            line_dirty  <= 1'b0;
            line_ovf    <= 1'b0;
            extra_lines <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            line_error  <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            vsync_out   <= vsync_q;
            href_out    <= emit;
            line_dirty  <= dirty_now;
            line_ovf    <= ovf_now | overflow;
            line_error  <= line_bad;
            frame_done  <= frame_end;
            frame_error <= frame_bad;
            if (href_rise_q) begin
                x_cnt   <= '0;
                col_cnt <= '0;
            end
            if (emit) begin
                pixel_out <= pair_pixel;
                x_cnt     <= col_cnt;
                col_cnt   <= col_cnt + 1'b1;
            end
            if (vs_rise_q) begin
                row_cnt     <= '0;
                extra_lines <= 1'b0;
            end else begin
                row_cnt     <= row_next;
                extra_lines <= extra_now;
            end
            if (frame_end) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign y_cnt = row_cnt;

endmodule
